alu_control_seq: RTL and testbench
==================================

# alu_control_seq

Parametrised successor to the single-cycle ALU control decoder for the MIPS EX stage. Decodes ALUOp and function field into a 4-bit ALUOperation as before, adds SUB/SLT/shift/MFHI/MFLO/ANDI/LUI decoding, and owns an iterative unsigned multiply/divide sequencer. The sequencer holds the HI/LO registers and stalls the pipeline while MULTU/DIVU execute.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width; must be ≥4.
- ALUOP_WIDTH, 3, width of ALUOp from main control.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ALUOp  in  ALUOP_WIDTH  class from main control.
- ALUFunction  in  6  instruction funct field.
- Valid  in  1  instruction in EX is real (not a bubble).
- Flush  in  1  synchronous abort of any in-flight mul/div.
- OperandA, OperandB  in  DATA_WIDTH  rs/rt values.
- ALUOperation  out  4  combinational ALU select.
- Stall  out  1  freeze IF/ID/EX.
- MulDivDone  out  1  one-cycle pulse when HI/LO have just been written.
- HI, LO  out  DATA_WIDTH  registered results.

## Operation
- ALUOp encodings: 111 R-type, 100 ADDI, 101 ORI, 110 ANDI, 011 LUI, 001 BEQ/BNE; anything else → 1001.
- R-type funct → ALUOperation: AND 100100→0000, OR 100101→0001, NOR 100111→0010, ADD 100000→0011, SUB 100010→0100, SLL 000000→0101, SRL 000010→0110, SLT 101010→0111, MFHI 010000→1010, MFLO 010010→1011, MULTU 011001→1100, DIVU 011011→1101; unlisted funct → 1001.
- I-type: ADDI→0011, ORI→0001, ANDI→0000, LUI→1000; BEQ/BNE→0100.
- ALUOperation is purely combinational, independent of sequencer state.
- Sequencer states: IDLE, MUL, DIV, DONE.
- IDLE: Valid & MULTU → latch operands, counter=DATA_WIDTH-1, go MUL; Valid & DIVU → same, go DIV.
- MUL: radix-2 shift-add, one multiplier bit per cycle, 2·DATA_WIDTH-bit product; at counter==0 write HI=product upper half, LO=lower half, go DONE.
- DIV: restoring division, one quotient bit per cycle; at counter==0 write LO=quotient, HI=remainder, go DONE.
- Divide by zero: no special path; result must be LO=all ones, HI=OperandA.
- DONE: MulDivDone=1, Stall=0, ignore inputs (same instruction still present), go IDLE next edge.
- Stall = (IDLE & Valid & (MULTU|DIVU)) | MUL | DIV.
- Flush in any state → IDLE next edge, HI/LO unchanged, no MulDivDone; Flush on the completion edge wins (no write).
- Valid=0 in IDLE: no state change regardless of decode.

## Timing
- Reset (asynchronous, active-low): state=IDLE, HI=LO=0, counter=0, Stall=0, MulDivDone=0; ALUOperation follows inputs; in-flight op discarded.
- Accept edge = end of cycle 0; MUL/DIV occupy cycles 1..DATA_WIDTH; HI/LO valid from cycle DATA_WIDTH+1 (DONE).
- Stall high for exactly DATA_WIDTH+1 cycles (0..DATA_WIDTH); pipeline advances at end of DONE cycle.
- Back-to-back MULTU/DIVU: next op accepted in IDLE at earliest cycle DATA_WIDTH+2.
- MFHI/MFLO in the instruction after MULTU/DIVU reads new HI/LO (no hazard).
- Counter width $clog2(DATA_WIDTH); intermediate sums are DATA_WIDTH+1 bits, no overflow flag.

## Structure
- alu_control_pkg: ALUOp codes, funct codes, ALUOperation codes, sequencer state enum.
- One sub-module: muldiv_iter (operand/partial registers, counter, add/subtract step); decoder and FSM stay in alu_control_seq.

## Test plan
- Sweep every ALUOp/funct pair in the table plus funct 111111 → matching ALUOperation, 1001 default; Stall=0.
- DATA_WIDTH=32, MULTU A=0xFFFFFFFF B=0xFFFFFFFF → Stall 33 cycles, HI=0xFFFFFFFE LO=0x00000001, one MulDivDone pulse.
- DIVU A=100 B=7 → LO=14 HI=2; DIVU A=5 B=0 → LO=0xFFFFFFFF HI=5.
- Flush in cycle 10 of MULTU 3×4 → IDLE next cycle, HI/LO keep prior values, no MulDivDone; Flush on completion edge → no write.
- reset low mid-DIV → immediate IDLE, HI=LO=0, Stall=0; subsequent DIVU 9/3 → LO=3 HI=0.
- DATA_WIDTH=8, MULTU 0xFF×0x02 then immediate DIVU 0x80/0x10 → HI=0x01 LO=0xFE, then LO=0x08 HI=0x00, stalls 9 cycles each.

Source files
------------

// File: rtl/alu_control_pkg.sv
// alu_control_pkg
//   Shared encodings for the EX-stage ALU control block: ALUOp classes from
//   main control, R-type funct codes, ALUOperation select codes and the
//   multiply/divide sequencer state enum.
package alu_control_pkg;

  // ALUOp classes driven by main control
  localparam logic [2:0] ALUOP_RTYPE  = 3'b111,
                         ALUOP_ADDI   = 3'b100,
                         ALUOP_ORI    = 3'b101,
                         ALUOP_ANDI   = 3'b110,
                         ALUOP_LUI    = 3'b011,
                         ALUOP_BRANCH = 3'b001;

  // R-type funct field values
  localparam logic [5:0] FN_AND   = 6'b100100,
                         FN_OR    = 6'b100101,
                         FN_NOR   = 6'b100111,
                         FN_ADD   = 6'b100000,
                         FN_SUB   = 6'b100010,
                         FN_SLL   = 6'b000000,
                         FN_SRL   = 6'b000010,
                         FN_SLT   = 6'b101010,
                         FN_MFHI  = 6'b010000,
                         FN_MFLO  = 6'b010010,
                         FN_MULTU = 6'b011001,
                         FN_DIVU  = 6'b011011;

  // ALUOperation select codes
  localparam logic [3:0] OPER_AND     = 4'b0000,
                         OPER_OR      = 4'b0001,
                         OPER_NOR     = 4'b0010,
                         OPER_ADD     = 4'b0011,
                         OPER_SUB     = 4'b0100,
                         OPER_SLL     = 4'b0101,
                         OPER_SRL     = 4'b0110,
                         OPER_SLT     = 4'b0111,
                         OPER_LUI     = 4'b1000,
                         OPER_INVALID = 4'b1001,
                         OPER_MFHI    = 4'b1010,
                         OPER_MFLO    = 4'b1011,
                         OPER_MULTU   = 4'b1100,
                         OPER_DIVU    = 4'b1101;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_MUL  = 2'd1,
    SEQ_DIV  = 2'd2,
    SEQ_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_control_seq_muldiv_iter.sv
// muldiv_iter
//   Datapath of the iterative unsigned multiply/divide unit. Holds the
//   working registers (partial high/low, multiplicand or divisor) and the
//   bit counter; performs one shift-add (multiply) or restoring-subtract
//   (divide) step per enabled cycle. The values the working registers would
//   take on this step are exported so the owner can commit them to HI/LO on
//   the final step without an extra cycle.
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   load           : capture op_a/op_b and preset the counter
//   step           : perform one iteration this cycle
//   is_div         : 1 = restoring divide step, 0 = shift-add multiply step
//   op_a, op_b     : multiplier/dividend and multiplicand/divisor
//   cnt_zero       : the current step is the last one
//   nxt_hi, nxt_lo : working registers after the current step
module muldiv_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  cnt_zero,
  output logic [DATA_WIDTH-1:0] nxt_hi,
  output logic [DATA_WIDTH-1:0] nxt_lo
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  // hi: partial product upper half / partial remainder
  // lo: multiplier being shifted out / dividend shifting into quotient
  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, den_q, den_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   mul_sum, rem_shift, rem_diff;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, den_q} : '0);
    rem_shift = {hi_q, lo_q[DATA_WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, den_q};
    if (is_div) begin
      // A zero divisor always "fits", giving an all-ones quotient and
      // leaving the dividend as the remainder.
      if (rem_shift >= {1'b0, den_q}) begin
        nxt_hi = rem_diff[DATA_WIDTH-1:0];
        nxt_lo = {lo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_shift[DATA_WIDTH-1:0];
        nxt_lo = {lo_q[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry of the add drops into the top of the shifted product.
      nxt_hi = mul_sum[DATA_WIDTH:1];
      nxt_lo = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    den_d = den_q;
    cnt_d = cnt_q;
    if (load) begin
      hi_d  = '0;
      lo_d  = op_a;
      den_d = op_b;
      cnt_d = CNT_W'(DATA_WIDTH - 1);
    end else if (step) begin
      hi_d  = nxt_hi;
      lo_d  = nxt_lo;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq
//   MIPS EX-stage ALU control: combinational ALUOp/funct decode to a 4-bit
//   ALUOperation, plus the MULTU/DIVU sequencer that owns HI/LO and stalls
//   the pipeline while an iterative multiply or divide runs.
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   ALUOp, ALUFunction  : class from main control, instruction funct field
//   Valid               : the EX instruction is real (not a bubble)
//   Flush               : abort any in-flight mul/div, no HI/LO write
//   OperandA, OperandB  : rs/rt values
//   ALUOperation        : combinational ALU select
//   Stall               : freeze IF/ID/EX
//   MulDivDone          : one-cycle pulse in the cycle after HI/LO were written
//   HI, LO              : registered mul/div results
//   dbg_state           : current sequencer state (seq_state_e encoding)
//
// Handshake: an instruction in EX is "offered" when Valid=1. The pipeline
// advances on every edge where Stall=0; while Stall=1 the same instruction
// and operands must be held. A MULTU/DIVU is accepted on the edge ending its
// first EX cycle (Stall already high), and the pipeline moves on at the end
// of the DONE cycle, when Stall is low and HI/LO hold the result.
module alu_control_seq
  import alu_control_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ALUOP_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ALUOP_WIDTH-1:0] ALUOp,
  input  logic [5:0]             ALUFunction,
  input  logic                   Valid,
  input  logic                   Flush,
  input  logic [DATA_WIDTH-1:0]  OperandA,
  input  logic [DATA_WIDTH-1:0]  OperandB,
  output logic [3:0]             ALUOperation,
  output logic                   Stall,
  output logic                   MulDivDone,
  output logic [DATA_WIDTH-1:0]  HI,
  output logic [DATA_WIDTH-1:0]  LO,
  output logic [1:0]             dbg_state
);

  seq_state_e            state_q, state_d;
  logic                  is_rtype, is_multu, is_divu;
  logic                  md_load, md_step, md_write, md_zero;
  logic [DATA_WIDTH-1:0] md_hi, md_lo;
  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // ---------------- decoder ----------------
  assign is_rtype = (ALUOp == ALUOP_WIDTH'(ALUOP_RTYPE));
  assign is_multu = is_rtype && (ALUFunction == FN_MULTU);
  assign is_divu  = is_rtype && (ALUFunction == FN_DIVU);

  always_comb begin
    ALUOperation = OPER_INVALID;
    if (is_rtype) begin
      case (ALUFunction)
        FN_AND:   ALUOperation = OPER_AND;
        FN_OR:    ALUOperation = OPER_OR;
        FN_NOR:   ALUOperation = OPER_NOR;
        FN_ADD:   ALUOperation = OPER_ADD;
        FN_SUB:   ALUOperation = OPER_SUB;
        FN_SLL:   ALUOperation = OPER_SLL;
        FN_SRL:   ALUOperation = OPER_SRL;
        FN_SLT:   ALUOperation = OPER_SLT;
        FN_MFHI:  ALUOperation = OPER_MFHI;
        FN_MFLO:  ALUOperation = OPER_MFLO;
        FN_MULTU: ALUOperation = OPER_MULTU;
        FN_DIVU:  ALUOperation = OPER_DIVU;
        default:  ALUOperation = OPER_INVALID;
      endcase
    end else if (ALUOp == ALUOP_WIDTH'(ALUOP_ADDI)) begin
      ALUOperation = OPER_ADD;
    end else if (ALUOp == ALUOP_WIDTH'(ALUOP_ORI)) begin
      ALUOperation = OPER_OR;
    end else if (ALUOp == ALUOP_WIDTH'(ALUOP_ANDI)) begin
      ALUOperation = OPER_AND;
    end else if (ALUOp == ALUOP_WIDTH'(ALUOP_LUI)) begin
      ALUOperation = OPER_LUI;
    end else if (ALUOp == ALUOP_WIDTH'(ALUOP_BRANCH)) begin
      ALUOperation = OPER_SUB;
    end
  end

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SEQ_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = SEQ_IDLE;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (Valid && is_multu)     state_d = SEQ_MUL;
          else if (Valid && is_divu) state_d = SEQ_DIV;
        end
        SEQ_MUL, SEQ_DIV: if (md_zero) state_d = SEQ_DONE;
        SEQ_DONE: state_d = SEQ_IDLE;
        default:  state_d = SEQ_IDLE;
      endcase
    end
  end

  always_comb begin
    Stall      = 1'b0;
    MulDivDone = 1'b0;
    md_load    = 1'b0;
    md_step    = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        Stall   = Valid && (is_multu || is_divu);
        md_load = Stall && !Flush;
      end
      SEQ_MUL, SEQ_DIV: begin
        Stall   = 1'b1;
        md_step = !Flush;
      end
      SEQ_DONE: MulDivDone = 1'b1;
      default: ;
    endcase
  end

  // A flush on the final step suppresses the write.
  assign md_write  = md_step && md_zero;
  assign dbg_state = state_q;

  muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (reset),
    .load     (md_load),
    .step     (md_step),
    .is_div   (state_q == SEQ_DIV),
    .op_a     (OperandA),
    .op_b     (OperandB),
    .cnt_zero (md_zero),
    .nxt_hi   (md_hi),
    .nxt_lo   (md_lo)
  );

  // ---------------- HI/LO ----------------
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (md_write) begin
      hi_d = md_hi;
      lo_d = md_lo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_alu_control_seq.sv
module tb_alu_control_seq;

  localparam int W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   alu_op;
  logic [5:0]   alu_fn;
  logic         valid, flush;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   oper;
  logic         stall, done;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  alu_control_seq #(.DATA_WIDTH(W), .ALUOP_WIDTH(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .ALUOp        (alu_op),
    .ALUFunction  (alu_fn),
    .Valid        (valid),
    .Flush        (flush),
    .OperandA     (op_a),
    .OperandB     (op_b),
    .ALUOperation (oper),
    .Stall        (stall),
    .MulDivDone   (done),
    .HI           (hi),
    .LO           (lo),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int             checks   = 0;
  int             failures = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   hi_m, lo_m;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [3:0] ref_oper(input logic [2:0] op, input logic [5:0] fn);
    case (op)
      3'b111: begin
        case (fn)
          6'b100100: return 4'd0;
          6'b100101: return 4'd1;
          6'b100111: return 4'd2;
          6'b100000: return 4'd3;
          6'b100010: return 4'd4;
          6'b000000: return 4'd5;
          6'b000010: return 4'd6;
          6'b101010: return 4'd7;
          6'b010000: return 4'd10;
          6'b010010: return 4'd11;
          6'b011001: return 4'd12;
          6'b011011: return 4'd13;
          default:   return 4'd9;
        endcase
      end
      3'b100:  return 4'd3;
      3'b101:  return 4'd1;
      3'b110:  return 4'd0;
      3'b011:  return 4'd8;
      3'b001:  return 4'd4;
      default: return 4'd9;
    endcase
  endfunction

  // {HI, LO} for an unsigned multiply or divide
  function automatic logic [2*W-1:0] ref_muldiv(input bit is_div, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    if (!is_div) return (2*W)'(a) * (2*W)'(b);
    if (b == '0) return {a, {W{1'b1}}};
    return {a % b, a / b};
  endfunction

  // Directed decode table: R-type funct sweep and the I-type classes
  logic [5:0] sw_fn  [13] = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010,
                              6'b000000, 6'b000010, 6'b101010, 6'b010000, 6'b010010,
                              6'b011001, 6'b011011, 6'b111111};
  logic [3:0] sw_fexp[13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                              4'd10, 4'd11, 4'd12, 4'd13, 4'd9};
  logic [2:0] sw_op  [7]  = '{3'b100, 3'b101, 3'b110, 3'b011, 3'b001, 3'b000, 3'b010};
  logic [3:0] sw_oexp[7]  = '{4'd3, 4'd1, 4'd0, 4'd8, 4'd4, 4'd9, 4'd9};

  // ---------------- driver tasks ----------------
  // Cycles with no mul/div offered: random decode, random Flush.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      alu_op = 3'($urandom_range(0, 7));
      alu_fn = 6'($urandom);
      valid  = 1'($urandom_range(0, 1));
      if (alu_op == 3'b111 && (alu_fn == 6'b011001 || alu_fn == 6'b011011)) valid = 1'b0;
      flush  = 1'($urandom_range(0, 1));
      op_a   = $urandom;
      op_b   = $urandom;
      #1;
      check_eq("idle_oper", 64'(oper), 64'(ref_oper(alu_op, alu_fn)));
      check_eq("idle_stall", 64'(stall), 64'd0);
      check_eq("idle_done", 64'(done), 64'd0);
      check_eq("idle_hi", 64'(hi), 64'(hi_m));
      check_eq("idle_lo", 64'(lo), 64'(lo_m));
    end
  endtask

  // One MULTU/DIVU held in EX from its first cycle (0) until the pipeline
  // moves on: end of DONE (cycle W+1), or the cycle carrying Flush.
  task automatic run_op(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int flush_at);
    bit             flushed;
    int             last;
    logic [2*W-1:0] r;
    flushed = (flush_at >= 0) && (flush_at <= W);
    last    = flushed ? flush_at : W + 1;
    if (!flushed) exp_q.push_back(ref_muldiv(is_div, a, b));
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      alu_op = 3'b111;
      alu_fn = is_div ? 6'b011011 : 6'b011001;
      valid  = 1'b1;
      flush  = (c == flush_at);
      op_a   = a;
      op_b   = b;
      #1;
      if (!flushed && c == W + 1) begin
        if (exp_q.size() > 0) begin
          r    = exp_q.pop_front();
          hi_m = r[2*W-1:W];
          lo_m = r[W-1:0];
        end
      end
      check_eq("op_oper", 64'(oper), is_div ? 64'd13 : 64'd12);
      check_eq("op_stall", 64'(stall), (c <= W) ? 64'd1 : 64'd0);
      check_eq("op_done", 64'(done), (!flushed && c == W + 1) ? 64'd1 : 64'd0);
      check_eq("op_hi", 64'(hi), 64'(hi_m));
      check_eq("op_lo", 64'(lo), 64'(lo_m));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset  = 1'b0;
    valid  = 1'b0;
    flush  = 1'b0;
    alu_op = 3'b000;
    alu_fn = 6'b000000;
    op_a   = '0;
    op_b   = '0;
    hi_m   = '0;
    lo_m   = '0;
    #1;
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'd0);
    check_eq("rst_oper", 64'(oper), 64'd9);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // decode sweep
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      alu_op = 3'b111;
      alu_fn = sw_fn[i];
      valid  = 1'b0;
      #1;
      check_eq("sweep_r_oper", 64'(oper), 64'(sw_fexp[i]));
      check_eq("sweep_r_stall", 64'(stall), 64'd0);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      alu_op = sw_op[i];
      alu_fn = 6'($urandom);
      valid  = 1'b1;
      #1;
      check_eq("sweep_i_oper", 64'(oper), 64'(sw_oexp[i]));
      check_eq("sweep_i_stall", 64'(stall), 64'd0);
    end
    idle_cycles(2);

    // directed mul/div
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    idle_cycles(1);
    run_op(1'b1, 32'd100, 32'd7, -1);
    idle_cycles(1);
    run_op(1'b1, 32'd5, 32'd0, -1);
    idle_cycles(1);
    run_op(1'b0, 32'd3, 32'd4, 10);
    idle_cycles(2);
    run_op(1'b0, 32'd3, 32'd4, W);
    idle_cycles(2);

    // asynchronous reset in the middle of a divide
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      alu_op = 3'b111;
      alu_fn = 6'b011011;
      valid  = 1'b1;
      flush  = 1'b0;
      op_a   = 32'd1000;
      op_b   = 32'd3;
    end
    @(negedge clk);
    valid = 1'b0;
    reset = 1'b0;
    hi_m  = '0;
    lo_m  = '0;
    #1;
    check_eq("midrst_state", 64'(dbg_state), 64'd0);
    check_eq("midrst_stall", 64'(stall), 64'd0);
    check_eq("midrst_hi", 64'(hi), 64'd0);
    check_eq("midrst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(1'b1, 32'd9, 32'd3, -1);

    // back-to-back: divide accepted in the cycle right after DONE
    run_op(1'b0, 32'h0000_00FF, 32'h0000_0002, -1);
    run_op(1'b1, 32'h0000_0080, 32'h0000_0010, -1);
    idle_cycles(1);

    // randomized mul/div with occasional flushes and gaps
    for (int n = 0; n < 24; n++) begin
      bit           d;
      logic [W-1:0] a, b;
      int           f;
      d = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      f = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W)) : -1;
      run_op(d, a, b, f);
      idle_cycles(int'($urandom_range(0, 2)));
    end
    idle_cycles(1);
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
